// File: rtl/fetch_unit.sv
// fetch_unit: PC generator feeding a 2-entry {pc, instruction} buffer.
// Ports: clk, rst (async active-low), fetch_addr/fetch_req/request_data
//   (instruction memory, combinational read), redirect/redirect_pc
//   (flush and refetch), stall (downstream backpressure),
//   inst_valid/inst_out/pc_out (head of buffer).
// Optional: FETCH_MISALIGN_TRAP_EN adds output misaligned, which latches
//   on a redirect to a non-word-aligned target and halts fetch until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] fetch_addr,
    output logic        fetch_req,
    input  logic [31:0] request_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out
);

    logic [31:0] pc;
    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [31:0] buf_pc   [2];
    logic [31:0] buf_inst [2];

    logic        pop_req;
    logic        pop;
    logic        push;
    logic        halted;
    logic [1:0]  count_nxt;
    logic [31:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            trap <= 1'b1;
        end
    end

    assign misaligned = trap;
    assign halted     = trap;
`else
    // Low target bits are don't-care when no trap is built in.
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign halted          = 1'b0;
`endif

    assign target     = {redirect_pc[31:2], 2'b00};
    assign fetch_addr = pc;
    assign inst_valid = (count != 2'd0);
    assign inst_out   = buf_inst[rd_ptr];
    assign pc_out     = buf_pc[rd_ptr];

    // Consumer handshake, before redirect gets a say.
    assign pop_req = inst_valid && !stall;

    // A redirect discards the head rather than consuming it.
    assign pop = pop_req && !redirect;

    // A full buffer can still accept a word when the head leaves this cycle.
    always_comb begin
        fetch_req = 1'b0;
        if (rst && !redirect && !halted) begin
            fetch_req = (count < 2'd2) || pop_req;
        end
    end

    assign push = fetch_req;

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_pc[i]   <= 32'h0;
                buf_inst[i] <= 32'h0;
            end
        end else if (redirect) begin
            pc     <= target;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            count <= count_nxt;
            if (push) begin
                buf_pc[wr_ptr]   <= pc;
                buf_inst[wr_ptr] <= request_data;
                wr_ptr           <= ~wr_ptr;
                pc               <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit against a simple
// word-indexed instruction memory (word i = 32'h1000_0000 + i).
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_addr;
    logic        fetch_req;
    logic [31:0] request_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int total;
    int bad;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_addr   (fetch_addr),
        .fetch_req    (fetch_req),
        .request_data (request_data),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misaligned   (misaligned),
`endif
        .inst_valid   (inst_valid),
        .inst_out     (inst_out),
        .pc_out       (pc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign request_data = 32'h1000_0000 + (fetch_addr >> 2);

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench 3 time units into the first cycle after release.
    task automatic do_reset();
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        total++;
        if (inst_valid !== 1'b0 || fetch_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: valid=%b req=%b want 0 0",
                     inst_valid, fetch_req);
        end
        total++;
        if (fetch_addr !== 32'h0 || inst_out !== 32'h0 || pc_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: addr=%h inst=%h pc=%h want all 0",
                     fetch_addr, inst_out, pc_out);
        end
        rst = 1'b1;
        #1;
        total++;
        if (fetch_req !== 1'b1 || fetch_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_first_req: req=%b addr=%h want 1 0",
                     fetch_req, fetch_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        total++;
        if (inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_c1_valid: got %b want 0", inst_valid);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            total++;
            if (inst_valid !== 1'b1 ||
                inst_out !== 32'h1000_0000 + k ||
                pc_out !== 32'(4 * k) ||
                fetch_addr !== 32'(4 * (k + 1))) begin
                bad++;
                $display("FAIL stream_%0d: v=%b inst=%h pc=%h addr=%h want 1 %h %h %h",
                         k, inst_valid, inst_out, pc_out, fetch_addr,
                         32'h1000_0000 + k, 4 * k, 4 * (k + 1));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        stall = 1'b1;
        #1;
        total++;
        if (fetch_req !== 1'b1 || pc_out !== 32'h0) begin
            bad++;
            $display("FAIL stall_c2: req=%b pc=%h want 1 0", fetch_req, pc_out);
        end
        repeat (3) begin
            step();
            #1;
            total++;
            if (fetch_req !== 1'b0 || fetch_addr !== 32'h8 ||
                pc_out !== 32'h0 || inst_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_full: req=%b addr=%h pc=%h v=%b want 0 8 0 1",
                         fetch_req, fetch_addr, pc_out, inst_valid);
            end
        end
        step();
        stall = 1'b0;
        #1;
        total++;
        if (fetch_req !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h1000_0000) begin
            bad++;
            $display("FAIL stall_release: req=%b pc=%h inst=%h want 1 0 10000000",
                     fetch_req, pc_out, inst_out);
        end
        for (int k = 1; k < 3; k++) begin
            step();
            #1;
            total++;
            if (inst_valid !== 1'b1 || pc_out !== 32'(4 * k) ||
                inst_out !== 32'h1000_0000 + k) begin
                bad++;
                $display("FAIL stall_drain_%0d: v=%b pc=%h inst=%h want 1 %h %h",
                         k, inst_valid, pc_out, inst_out, 4 * k, 32'h1000_0000 + k);
            end
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        step();
        stall = 1'b1;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        total++;
        if (fetch_req !== 1'b0) begin
            bad++;
            $display("FAIL redir_full_req: got %b want 0", fetch_req);
        end
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        #1;
        total++;
        if (inst_valid !== 1'b0 || fetch_addr !== 32'h40 || fetch_req !== 1'b1) begin
            bad++;
            $display("FAIL redir_full_n1: v=%b addr=%h req=%b want 0 40 1",
                     inst_valid, fetch_addr, fetch_req);
        end
        step();
        #1;
        total++;
        if (inst_valid !== 1'b1 || inst_out !== 32'h1000_0010 || pc_out !== 32'h40) begin
            bad++;
            $display("FAIL redir_full_n2: v=%b inst=%h pc=%h want 1 10000010 40",
                     inst_valid, inst_out, pc_out);
        end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        #1;
        step();
        redirect = 1'b0;
        #1;
        total++;
        if (inst_valid !== 1'b0 || fetch_addr !== 32'h80) begin
            bad++;
            $display("FAIL redir_pop_n1: v=%b addr=%h want 0 80",
                     inst_valid, fetch_addr);
        end
        step();
        #1;
        total++;
        if (inst_valid !== 1'b1 || pc_out !== 32'h80 || inst_out !== 32'h1000_0020) begin
            bad++;
            $display("FAIL redir_pop_n2: v=%b pc=%h inst=%h want 1 80 10000020",
                     inst_valid, pc_out, inst_out);
        end
        step();
        #1;
        total++;
        if (pc_out !== 32'h84) begin
            bad++;
            $display("FAIL redir_pop_n3: pc=%h want 84", pc_out);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        #1;
        total++;
        if (fetch_addr !== 32'hFFFF_FFFC || fetch_req !== 1'b1) begin
            bad++;
            $display("FAIL wrap_addr: addr=%h req=%b want fffffffc 1",
                     fetch_addr, fetch_req);
        end
        step();
        #1;
        total++;
        if (fetch_addr !== 32'h0 || pc_out !== 32'hFFFF_FFFC ||
            inst_out !== 32'h4FFF_FFFF) begin
            bad++;
            $display("FAIL wrap_next: addr=%h pc=%h inst=%h want 0 fffffffc 4fffffff",
                     fetch_addr, pc_out, inst_out);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        stall = 1'b1;
        step();
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (inst_valid !== 1'b0 || fetch_addr !== 32'h0 || fetch_req !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: v=%b addr=%h req=%b want 0 0 0",
                     inst_valid, fetch_addr, fetch_req);
        end
        stall = 1'b0;
    endtask

    task automatic test_misalign();
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'h42;
        step();
        redirect = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        total++;
        if (misaligned !== 1'b1 || fetch_req !== 1'b0) begin
            bad++;
            $display("FAIL misalign_set: mis=%b req=%b want 1 0",
                     misaligned, fetch_req);
        end
        step();
        #1;
        total++;
        if (misaligned !== 1'b1 || fetch_req !== 1'b0 || inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL misalign_hold: mis=%b req=%b v=%b want 1 0 0",
                     misaligned, fetch_req, inst_valid);
        end
`else
        total++;
        if (fetch_addr !== 32'h40 || fetch_req !== 1'b1) begin
            bad++;
            $display("FAIL misalign_ignore: addr=%h req=%b want 40 1",
                     fetch_addr, fetch_req);
        end
        step();
        #1;
        total++;
        if (pc_out !== 32'h40 || inst_out !== 32'h1000_0010) begin
            bad++;
            $display("FAIL misalign_data: pc=%h inst=%h want 40 10000010",
                     pc_out, inst_out);
        end
`endif
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, word-aligned PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port fetch_addr  output  32  byte address presented to instruction memory.
REQ-005 SHALL have port fetch_req  output  1  fetch request; memory returns request_data combinationally in the same cycle.
REQ-006 SHALL have port request_data  input  32  instruction word from instruction memory.
REQ-007 SHALL have port redirect  input  1  branch/jump taken; flush and refetch from redirect_pc.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port stall  input  1  downstream not ready; head entry not consumed.
REQ-010 SHALL have port inst_valid  output  1  inst_out/pc_out hold a valid fetched instruction.
REQ-011 SHALL have port inst_out  output  32  instruction at head of buffer.
REQ-012 SHALL have port pc_out  output  32  byte address of inst_out.

Function
REQ-013 SHALL hold a 32-bit PC register; fetch_addr SHALL equal PC at all times.
REQ-014 SHALL contain a 2-entry FIFO of {pc, instruction}, with count 0..2, read/write pointers wrapping modulo 2.
REQ-015 SHALL assert fetch_req when FIFO count < 2, or count == 2 and a pop occurs this cycle, and no redirect is active.
REQ-016 On a cycle with fetch_req=1: push {PC, request_data} into FIFO and PC <= PC + 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-017 Pop SHALL occur when inst_valid=1 and stall=0; inst_valid SHALL equal (count != 0).
REQ-018 Simultaneous push and pop SHALL leave count unchanged, including at count==2.
REQ-019 When full (count==2) and stall=1, fetch_req SHALL be 0 and PC SHALL hold.
REQ-020 Redirect has priority over push/pop: FIFO count <= 0, PC <= {redirect_pc[31:2],2'b00}, fetch_req=0 that cycle; the same-cycle head entry is discarded, not popped.
REQ-021 First instruction at the redirect target SHALL appear on inst_out 1 cycle after redirect deasserts fetch (latency: redirect cycle N, fetch at N+1, inst_valid at N+2).
REQ-022 Fetch latency SHALL be 1 cycle: data pushed at edge N appears on inst_out in cycle N+1.
REQ-023 Outputs inst_out/pc_out SHALL be registered FIFO contents, never combinational from request_data.

Reset
REQ-024 While rst=0: PC=RESET_PC, count=0, pointers=0, inst_valid=0, inst_out=0, pc_out=0, fetch_req=0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered entries immediately, independent of clk.
REQ-026 First fetch_req=1 SHALL occur in the first cycle after rst deasserts, fetch_addr=RESET_PC.

Configuration
REQ-027 Macro FETCH_MISALIGN_TRAP_EN SHALL, when defined, add output misaligned (1 bit): on redirect with redirect_pc[1:0]!=0, misaligned sets to 1 and fetch_req stays 0 until reset; reset clears it to 0.
REQ-028 Without FETCH_MISALIGN_TRAP_EN, port misaligned SHALL not exist and redirect_pc[1:0] SHALL be ignored (forced to 00).

Verification
REQ-029 Reset release, RESET_PC=0, stall=0, memory word i = 32'h1000_0000+i -> fetch_addr 0,4,8...; inst_out 32'h1000_0000 at cycle 2 with pc_out 0, one instruction per cycle thereafter.
REQ-030 Stall held 4 cycles after first valid -> FIFO fills to 2, fetch_req=0, PC holds at 8; on release inst_out sequence 0,4,8 with no loss or duplicate.
REQ-031 Redirect to 32'h40 while count==2 -> inst_valid=0 next cycle, fetch_addr=32'h40, inst_out=word at 32'h40 two cycles after redirect.
REQ-032 Redirect and stall=0 pop in same cycle -> head not reported consumed twice, FIFO empty, resumes at target.
REQ-033 rst asserted between clock edges with count==2 -> inst_valid=0 immediately, PC=RESET_PC.
REQ-034 With FETCH_MISALIGN_TRAP_EN, redirect to 32'h42 -> misaligned=1, fetch_req=0 held; without macro, fetch_addr=32'h40.
